// File: rtl/wb_core_bus_arbiter_if.sv
// rtl/wb_core_bus_arbiter_if.sv - Wishbone core_* bus between the arbiter and controller memory
interface wb_core_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    core_cyc;
  logic                    core_stb;
  logic                    core_we;
  logic [DATA_WIDTH/8-1:0] core_sel;
  logic [ADDR_WIDTH-1:0]   core_addr;
  logic [DATA_WIDTH-1:0]   core_data_out;
  logic [DATA_WIDTH-1:0]   core_data_in;
  logic                    core_ack;

  // Arbiter side drives the cycle, memory side answers with ack and read data
  modport master (
    output core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
    input  core_data_in, core_ack
  );

  modport slave (
    input  core_cyc, core_stb, core_we, core_sel, core_addr, core_data_out,
    output core_data_in, core_ack
  );
endinterface

// File: rtl/wb_core_bus_arbiter.sv
// rtl/wb_core_bus_arbiter.sv - instruction/data arbiter onto one Wishbone master with ack timeout
module wb_core_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_PRIORITY  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    ireq_i,
  input  logic [ADDR_WIDTH-1:0]   iaddr_i,
  output logic [DATA_WIDTH-1:0]   idata_o,
  output logic                    iack_o,
  input  logic                    dreq_i,
  input  logic                    dwe_i,
  input  logic [DATA_WIDTH/8-1:0] dsel_i,
  input  logic [ADDR_WIDTH-1:0]   daddr_i,
  input  logic [DATA_WIDTH-1:0]   ddata_i,
  output logic [DATA_WIDTH-1:0]   ddata_o,
  output logic                    dack_o,
  output logic                    berr_o,
  wb_core_bus_arbiter_if.master   core
);

  localparam int SW = DATA_WIDTH / 8;
  // Counter holds the number of ack-less BUS cycles already finished; expiry is
  // decided in the last allowed cycle so cyc drops after exactly TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit T_EN = (TIMEOUT_CYCLES > 0);
  localparam bit D_WINS = (DATA_PRIORITY != 0);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} state_t;

  state_t            state;
  logic              last_data;
  logic [CW-1:0]     tcount;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic [SW-1:0]     sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic              pick_i;
  logic              pick_d;
  logic              expire;

  assign core.core_cyc      = cyc_q;
  assign core.core_stb      = stb_q;
  assign core.core_we       = we_q;
  assign core.core_sel      = sel_q;
  assign core.core_addr     = addr_q;
  assign core.core_data_out = wdata_q;

  assign expire = T_EN && (tcount == T_LAST);

  // Grant decision: a lone request wins, a tie goes to data or to whoever was not served last
  always_comb begin
    pick_d = 1'b0;
    if (dreq_i && ireq_i) begin
      pick_d = D_WINS || !last_data;
    end else begin
      pick_d = dreq_i;
    end
    pick_i = ireq_i && !pick_d;
  end

  // Arbitration FSM with registered bus signals and completion pulses
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_data <= 1'b1;
      tcount    <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idata_o   <= '0;
      ddata_o   <= '0;
      iack_o    <= 1'b0;
      dack_o    <= 1'b0;
      berr_o    <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      iack_o <= 1'b0;
      dack_o <= 1'b0;
      berr_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_i) begin
            state     <= BUS_I;
            last_data <= 1'b0;
            tcount    <= '0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            we_q      <= 1'b0;
            sel_q     <= '1;
            addr_q    <= iaddr_i;
          end else if (pick_d) begin
            state     <= BUS_D;
            last_data <= 1'b1;
            tcount    <= '0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            we_q      <= dwe_i;
            sel_q     <= dsel_i;
            addr_q    <= daddr_i;
            wdata_q   <= ddata_i;
          end
        end
        BUS_I, BUS_D: begin
          if (core.core_ack || expire) begin
            state  <= DONE;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            berr_o <= !core.core_ack;
            if (state == BUS_I) begin
              iack_o  <= 1'b1;
              idata_o <= core.core_ack ? core.core_data_in : '0;
            end else begin
              dack_o  <= 1'b1;
              ddata_o <= core.core_ack ? core.core_data_in : '0;
            end
          end else if (T_EN) begin
            tcount <= tcount + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// tb/tb_wb_core_bus_arbiter.sv - directed bench, round-robin and data-priority arbiters against a transaction model
`timescale 1ns/1ps
module tb_wb_core_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [SW-1:0] dsel = '0;
  logic [DW-1:0] ddata_w = '0;
  logic [DW-1:0] rdata_cfg = '0;
  int   wait_cfg = 0;
  logic force_ack = 1'b0;
  logic ack_r [2];

  logic [1:0] iack_o, dack_o, berr_o;
  logic [DW-1:0] idata_o [2];
  logic [DW-1:0] ddata_o [2];

  int n_pass = 0;
  int n_total = 0;

  wb_core_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  wb_core_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.core_ack = ack_r[0];
  assign bus_b.core_ack = ack_r[1];
  assign bus_a.core_data_in = rdata_cfg;
  assign bus_b.core_data_in = rdata_cfg;

  wb_core_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .ireq_i(ireq), .iaddr_i(iaddr), .idata_o(idata_o[0]),
    .iack_o(iack_o[0]), .dreq_i(dreq), .dwe_i(dwe), .dsel_i(dsel), .daddr_i(daddr),
    .ddata_i(ddata_w), .ddata_o(ddata_o[0]), .dack_o(dack_o[0]), .berr_o(berr_o[0]), .core(bus_a));

  wb_core_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .ireq_i(ireq), .iaddr_i(iaddr), .idata_o(idata_o[1]),
    .iack_o(iack_o[1]), .dreq_i(dreq), .dwe_i(dwe), .dsel_i(dsel), .daddr_i(daddr),
    .ddata_i(ddata_w), .ddata_o(ddata_o[1]), .dack_o(dack_o[1]), .berr_o(berr_o[1]), .core(bus_b));

  logic [1:0] cyc_w, stb_w, we_w;
  logic [SW-1:0] sel_w [2];
  logic [AW-1:0] addr_w [2];
  logic [DW-1:0] wdat_w [2];
  assign cyc_w = {bus_b.core_cyc, bus_a.core_cyc};
  assign stb_w = {bus_b.core_stb, bus_a.core_stb};
  assign we_w  = {bus_b.core_we, bus_a.core_we};
  assign sel_w[0] = bus_a.core_sel;
  assign sel_w[1] = bus_b.core_sel;
  assign addr_w[0] = bus_a.core_addr;
  assign addr_w[1] = bus_b.core_addr;
  assign wdat_w[0] = bus_a.core_data_out;
  assign wdat_w[1] = bus_b.core_data_out;

  initial forever #5 sys_clk = ~sys_clk;

  // Transaction-level expectation: who owns the bus, how long it has waited, what the pins show
  typedef struct {
    bit busy;
    bit cool;
    bit last_d;
    bit owner_d;
    int age;
    logic cyc, stb, we, iack, dack, berr;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, idata, ddata;
  } mdl_t;
  mdl_t m [2];

  function automatic mdl_t model_reset();
    mdl_t r;
    r.busy = 0; r.cool = 0; r.last_d = 1; r.owner_d = 0; r.age = 0;
    r.cyc = 0; r.stb = 0; r.we = 0; r.iack = 0; r.dack = 0; r.berr = 0;
    r.sel = '0; r.addr = '0; r.wdata = '0; r.idata = '0; r.ddata = '0;
    return r;
  endfunction

  function automatic mdl_t model_step(mdl_t s, bit dp, logic ack);
    mdl_t n = s;
    bit give_d;
    n.stb = 0; n.iack = 0; n.dack = 0; n.berr = 0;
    if (s.cool) begin
      n.cool = 0;
    end else if (s.busy) begin
      n.age = s.age + 1;
      if (ack || n.age == TO) begin
        n.busy = 0; n.cool = 1; n.cyc = 0; n.we = 0; n.sel = '0;
        n.berr = !ack;
        if (s.owner_d) begin n.dack = 1; n.ddata = ack ? rdata_cfg : '0; end
        else begin n.iack = 1; n.idata = ack ? rdata_cfg : '0; end
      end
    end else if (ireq || dreq) begin
      give_d = (ireq && dreq) ? (dp || !s.last_d) : dreq;
      n.busy = 1; n.age = 0; n.owner_d = give_d; n.last_d = give_d;
      n.cyc = 1; n.stb = 1;
      if (give_d) begin n.we = dwe; n.sel = dsel; n.addr = daddr; n.wdata = ddata_w; end
      else begin n.we = 0; n.sel = '1; n.addr = iaddr; end
    end
    return n;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
  endtask

  task automatic compare_dut(input int k);
    check("core_cyc", k, cyc_w[k], m[k].cyc);
    check("core_stb", k, stb_w[k], m[k].stb);
    check("core_we", k, we_w[k], m[k].we);
    check("core_sel", k, sel_w[k], m[k].sel);
    check("core_addr", k, addr_w[k], m[k].addr);
    check("iack_o", k, iack_o[k], m[k].iack);
    check("dack_o", k, dack_o[k], m[k].dack);
    check("berr_o", k, berr_o[k], m[k].berr);
    check("idata_o", k, idata_o[k], m[k].idata);
    check("ddata_o", k, ddata_o[k], m[k].ddata);
    if (m[k].we) check("core_data_out", k, wdat_w[k], m[k].wdata);
  endtask

  // Model advances on the same edges as the designs
  initial begin
    m[0] = model_reset();
    m[1] = model_reset();
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) begin
        m[0] = model_reset();
        m[1] = model_reset();
      end else begin
        m[0] = model_step(m[0], 1'b0, ack_r[0]);
        m[1] = model_step(m[1], 1'b1, ack_r[1]);
      end
    end
  end

  // Every falling edge: both designs against their models
  initial forever begin
    @(negedge sys_clk);
    for (int k = 0; k < 2; k++) compare_dut(k);
  end

  // Memory responders: ack wait_cfg cycles after the strobe cycle, never when wait_cfg < 0
  initial begin
    bit act [2];
    int cnt [2];
    act[0] = 0; act[1] = 0; cnt[0] = 0; cnt[1] = 0;
    ack_r[0] = 0; ack_r[1] = 0;
    forever begin
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          act[k] = 0; ack_r[k] = 0;
        end else begin
          if (!cyc_w[k]) act[k] = 0;
          if (stb_w[k]) begin act[k] = 1; cnt[k] = 0; end
          ack_r[k] = force_ack || (act[k] && wait_cfg >= 0 && cnt[k] == wait_cfg);
          if (act[k]) begin
            if (ack_r[k]) act[k] = 0;
            else cnt[k]++;
          end
        end
      end
    end
  end

  int t_stb_at, t_ack_at, t_cyc_n;
  logic t_berr, t_we;
  logic [SW-1:0] t_sel;
  logic [DW-1:0] t_data, t_wdata;

  task automatic run_xact(input bit is_d, input bit we, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [DW-1:0] wd, input int wt);
    @(negedge sys_clk);
    wait_cfg = wt;
    t_stb_at = -1; t_ack_at = -1; t_cyc_n = 0; t_berr = 0;
    if (is_d) begin dreq = 1; dwe = we; daddr = a; dsel = s; ddata_w = wd; end
    else begin ireq = 1; iaddr = a; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge sys_clk);
      if (bus_a.core_cyc) t_cyc_n++;
      if (bus_a.core_stb) begin
        t_stb_at = c; t_we = bus_a.core_we; t_sel = bus_a.core_sel; t_wdata = bus_a.core_data_out;
      end
      if (is_d ? dack_o[0] : iack_o[0]) begin
        t_ack_at = c; t_berr = berr_o[0]; t_data = is_d ? ddata_o[0] : idata_o[0];
        break;
      end
    end
    ireq = 0; dreq = 0;
    if (t_ack_at < 0) check("ack_wait", 0, 0, 1);
  endtask

  initial begin
    int qa[$];
    int qb[$];
    repeat (3) @(negedge sys_clk);
    check("reset_cyc", 0, bus_a.core_cyc, 0);
    check("reset_ddata", 1, ddata_o[1], 0);
    rst_n = 1;

    // 1: fetch with one wait state
    rdata_cfg = 32'h0000_0013;
    run_xact(0, 0, 32'h10, '0, '0, 1);
    check("t1_stb_at", 0, t_stb_at, 1);
    check("t1_we", 0, t_we, 0);
    check("t1_sel", 0, t_sel, 4'hF);
    check("t1_ack_at", 0, t_ack_at, 3);
    check("t1_idata", 0, t_data, 32'h13);
    @(negedge sys_clk);
    check("t1_single_pulse", 0, iack_o[0], 0);

    // 2: byte-masked write
    rdata_cfg = 32'h5555_AAAA;
    run_xact(1, 1, 32'h8000_0004, 4'b0011, 32'hDEAD_BEEF, 0);
    check("t2_we", 0, t_we, 1);
    check("t2_sel", 0, t_sel, 4'b0011);
    check("t2_wdata", 0, t_wdata, 32'hDEAD_BEEF);
    check("t2_ack_at", 0, t_ack_at, 2);
    check("t2_berr", 0, t_berr, 0);
    @(negedge sys_clk);
    check("t2_single_pulse", 0, dack_o[0], 0);

    // 4: data read never acknowledged, then a normal fetch
    run_xact(1, 0, 32'h2000, 4'hF, '0, -1);
    check("t4_cyc_cycles", 0, t_cyc_n, TO);
    check("t4_ack_at", 0, t_ack_at, TO + 1);
    check("t4_berr", 0, t_berr, 1);
    check("t4_ddata", 0, t_data, 0);
    rdata_cfg = 32'h0000_0093;
    run_xact(0, 0, 32'h14, '0, '0, 0);
    check("t4_fetch_berr", 0, t_berr, 0);
    check("t4_fetch_data", 0, t_data, 32'h93);

    // 5: ack lands in the expiry cycle
    rdata_cfg = 32'hCAFE_F00D;
    run_xact(1, 0, 32'h2004, 4'hF, '0, TO - 1);
    check("t5_ack_at", 0, t_ack_at, TO + 1);
    check("t5_berr", 0, t_berr, 0);
    check("t5_ddata", 0, t_data, 32'hCAFE_F00D);

    // 3: both requests held from reset
    @(negedge sys_clk);
    rst_n = 0;
    @(negedge sys_clk);
    rst_n = 1;
    wait_cfg = 0; dwe = 0; iaddr = 32'h40; daddr = 32'h3000; dsel = 4'hF;
    ireq = 1; dreq = 1;
    for (int c = 0; c < 60 && qb.size() < 5; c++) begin
      @(negedge sys_clk);
      if (iack_o[0]) qa.push_back(1);
      if (dack_o[0]) qa.push_back(2);
      if (iack_o[1]) qb.push_back(1);
      if (dack_o[1]) qb.push_back(2);
      if (qb.size() == 4) dreq = 0;
    end
    ireq = 0; dreq = 0;
    check("t3_rr_len", 0, qa.size() >= 4, 1);
    check("t3_dp_len", 1, qb.size(), 5);
    if (qa.size() >= 4) begin
      check("t3_rr_0", 0, qa[0], 1);
      check("t3_rr_1", 0, qa[1], 2);
      check("t3_rr_2", 0, qa[2], 1);
      check("t3_rr_3", 0, qa[3], 2);
    end
    if (qb.size() == 5) begin
      check("t3_dp_0", 1, qb[0], 2);
      check("t3_dp_3", 1, qb[3], 2);
      check("t3_dp_4", 1, qb[4], 1);
    end
    repeat (3) @(negedge sys_clk);

    // 6: reset while a fetch holds the bus
    wait_cfg = -1; iaddr = 32'h80; ireq = 1;
    repeat (3) @(negedge sys_clk);
    check("t6_cyc_before", 0, bus_a.core_cyc, 1);
    #2 rst_n = 0;
    #1;
    check("t6_cyc_async", 0, bus_a.core_cyc, 0);
    check("t6_stb_async", 1, bus_b.core_stb, 0);
    check("t6_iack_async", 0, iack_o[0], 0);
    ireq = 0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1;
    force_ack = 1;
    repeat (3) @(negedge sys_clk);
    check("t6_no_iack", 0, iack_o[0], 0);
    check("t6_no_dack", 0, dack_o[0], 0);
    force_ack = 0;
    rdata_cfg = 32'h0000_0117;
    run_xact(0, 0, 32'h84, '0, '0, 1);
    check("t6_stb_at", 0, t_stb_at, 1);
    check("t6_ack_at", 0, t_ack_at, 3);
    check("t6_idata", 0, t_data, 32'h117);
    repeat (2) @(negedge sys_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
